stack_cache_ctl: RTL and testbench
==================================

Name: stack_cache_ctl

Overview:
Controls the on-chip operand stack cache for the stack CPU pipeline. Holds the top DEPTH stack entries in a circular register buffer and supplies top_0/top_n to stage 2. Absorbs pops from stage 2 and pushes from stage 5. Spills the bottom entries to data memory and fills them back over a req/ack port, and raises stall_2a when stage 2 cannot safely proceed.

Parameters:
DEPTH, 8, cache entries; power of 2, >= 8
W, 35, stack entry width
AW, 16, memory word-address width; memory stack region holds up to 2^AW entries
HI_WM, 5, resident count at or above which a spill is started
LO_WM, 2, resident count at or below which a fill is started
GUARD, 3, pushes possibly in flight in stages 3-5; stall when count >= DEPTH-GUARD

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
pop_2a  in  1  stage-2 instruction pops one entry; takes effect only when stall_2a=0
need_2a  in  2  entries stage 2 needs resident (0..2)
push_5a  in  1  writeback pushes an entry this cycle
to_push_5a  in  W  pushed value
stall_2a  out  1  hold stage 2
top_0_2a  out  W  top entry (0 if count<1)
top_n_2a  out  W  second entry (0 if count<2)
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=spill write, 0=fill read
mem_addr  out  AW  memory stack slot
mem_wdata  out  W  spill data
mem_rdata  in  W  fill data, valid with mem_ack
mem_ack  in  1  one-cycle completion
count  out  $clog2(DEPTH)+1  resident entries
mem_count  out  AW+1  entries held in memory
ovf_err  out  1  sticky: push dropped on full cache
unf_err  out  1  sticky: need/pop exceeded total stack

Behaviour:
- Reset (async, rst_b=0): count=0, mem_count=0, top/bottom pointers=0, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall_2a=0, ovf_err=0, unf_err=0. An in-flight memory transaction is abandoned. Buffer contents need not be cleared.
- Buffer: top pointer tp and bottom pointer bp, both mod DEPTH. top_0_2a=buf[tp-1] and top_n_2a=buf[tp-2]; both are combinational from registered state.
- Effective pop: pop_eff = pop_2a & ~stall_2a & (count>=1).
- Pop only: tp--, count--.
- Push only: buf[tp]<=data, tp++, count++.
- Pop and push in the same cycle: buf[tp-1]<=data; tp and count unchanged.
- Push with count==DEPTH and no same-cycle pop: push is dropped and ovf_err<=1.
- stall_2a = (need_2a > count & mem_count>0) | (fill in progress & need_2a>count) | (count >= DEPTH-GUARD). This is combinational.
- Underflow: if need_2a > count + mem_count, or pop_2a=1 with count+mem_count==0, then unf_err<=1 and no stall is raised for that condition.
- FSM states: IDLE, SPILL, FILL.
- IDLE -> SPILL when count>=HI_WM and mem_count < 2^AW. On entry:
  - mem_req=1, mem_we=1, mem_addr=mem_count, mem_wdata=buf[bp] (latched).
  - bp++, count-- in the same cycle; this combines arithmetically with any push/pop that cycle.
- SPILL -> IDLE on mem_ack: mem_count++, mem_req=0.
- IDLE -> FILL when count<=LO_WM, mem_count>0, count<DEPTH, and SPILL is not triggered. On entry: mem_req=1, mem_we=0, mem_addr=mem_count-1.
- FILL -> IDLE on mem_ack: buf[bp-1]<=mem_rdata, bp--, count++, mem_count--, mem_req=0.
- A fill write and a push may occur in the same cycle; they write different slots.
- Priority: SPILL over FILL. At most one outstanding transaction. IDLE lasts at least 1 cycle between transactions.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
- Latencies:
  - Pop/push update count the cycle after the event.
  - Spill start is 1 cycle after count reaches HI_WM.
  - A filled entry is visible on top_* the cycle after mem_ack.
- Wrap-around: tp/bp wrap mod DEPTH. count is the authority for full/empty, never pointer equality.

Test Plan:
- Reset with rst_b low mid-spill (mem_req=1) -> all outputs zero immediately, asynchronously; mem_req=0 with no clock edge.
- 5 pushes of 0x1..0x5, no pops -> count=5; next cycle mem_req=1, mem_we=1, mem_addr=0, mem_wdata=0x1, count=4; ack -> mem_count=1.
- Same-cycle pop_2a and push_5a of 0x7FFFFFFFF with count=3 -> count stays 3, top_0_2a=0x7FFFFFFFF, top_n_2a unchanged.
- count=1, mem_count=2, need_2a=2 -> stall_2a=1 and a FILL read at addr 1; ack with 0x0AB -> next cycle count=2, top_n_2a=0x0AB, stall_2a=0.
- count=0, mem_count=0, need_2a=1, pop_2a=1 -> unf_err=1, stall_2a=0, count stays 0.
- Hold mem_ack low with count rising to DEPTH-GUARD=5 -> stall_2a=1. In-flight pushes fill to 8; a 9th push sets ovf_err=1 and count stays 8. Pointers wrap across index 7->0 with correct top values.

Source files
------------

// File: rtl/stack_cache_ctl.sv
// Operand stack cache: a circular buffer holding the top DEPTH entries, with
// spill/fill of the bottom entries to data memory over a req/ack port.
module stack_cache_ctl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 35,
  parameter int unsigned AW    = 16,
  parameter int unsigned HI_WM = 5,
  parameter int unsigned LO_WM = 2,
  parameter int unsigned GUARD = 3,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1,
  localparam int unsigned MW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          pop_2a,
  input  logic [1:0]    need_2a,
  input  logic          push_5a,
  input  logic [W-1:0]  to_push_5a,
  output logic          stall_2a,
  output logic [W-1:0]  top_0_2a,
  output logic [W-1:0]  top_n_2a,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_ack,
  output logic [CW-1:0] count,
  output logic [MW-1:0] mem_count,
  output logic          ovf_err,
  output logic          unf_err
);

  localparam int unsigned TW = AW + 2;

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    ent_q [DEPTH];
  logic [PW-1:0]   tp_q, bp_q;

  logic            req_d, we_d;
  logic [AW-1:0]   addr_d;
  logic [W-1:0]    wdata_d;

  logic [TW-1:0]   total;
  logic            need_unf, pop_unf, need_gt, mem_some;
  logic            pop_eff, push_acc, push_only, pop_only;
  logic            spill_start, fill_start, spill_done, fill_acc, push_fit;
  logic [PW-1:0]   wr_idx;

  // Hazard, underflow and transaction-trigger decode from registered state.
  always_comb begin
    total       = TW'(count) + TW'(mem_count);
    need_unf    = TW'(need_2a) > total;
    pop_unf     = pop_2a & (total == '0);
    need_gt     = CW'(need_2a) > count;
    mem_some    = (mem_count != '0);
    stall_2a    = (~need_unf & need_gt & (mem_some | (state_q == FILL)))
                | (count >= CW'(DEPTH - GUARD));
    pop_eff     = pop_2a & ~stall_2a & (count != '0);
    spill_start = (state_q == IDLE) & (count >= CW'(HI_WM)) & ~mem_count[AW];
    fill_start  = (state_q == IDLE) & ~spill_start & (count <= CW'(LO_WM))
                & mem_some & (count < CW'(DEPTH));
    spill_done  = (state_q == SPILL) & mem_ack;
    // A fill landing on a full cache is abandoned; the entry stays in memory.
    fill_acc    = (state_q == FILL) & mem_ack & (count < CW'(DEPTH));
    push_fit    = (count + CW'(fill_acc)) < CW'(DEPTH);
    push_acc    = push_5a & (pop_eff | push_fit);
    push_only   = push_acc & ~pop_eff;
    pop_only    = pop_eff & ~push_acc;
    wr_idx      = pop_eff ? tp_q - PW'(1) : tp_q;
  end

  always_comb begin
    top_0_2a = (count >= CW'(1)) ? ent_q[tp_q - PW'(1)] : '0;
    top_n_2a = (count >= CW'(2)) ? ent_q[tp_q - PW'(2)] : '0;
  end

  // Memory-port FSM: next state and next port values.
  always_comb begin
    state_d = state_q;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    unique case (state_q)
      IDLE: begin
        if (spill_start) begin
          state_d = SPILL;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = AW'(mem_count);
          wdata_d = ent_q[bp_q];
        end else if (fill_start) begin
          state_d = FILL;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = AW'(mem_count - MW'(1));
        end
      end
      SPILL, FILL: begin
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

  // Pointers and occupancy: push/pop, spill and fill combine arithmetically.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tp_q      <= '0;
      bp_q      <= '0;
      count     <= '0;
      mem_count <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else begin
      tp_q      <= tp_q + PW'(push_only) - PW'(pop_only);
      bp_q      <= bp_q + PW'(spill_start) - PW'(fill_acc);
      count     <= count + CW'(push_only) + CW'(fill_acc)
                 - CW'(pop_only) - CW'(spill_start);
      mem_count <= mem_count + MW'(spill_done) - MW'(fill_acc);
      if (push_5a && !push_acc) ovf_err <= 1'b1;
      if (need_unf || pop_unf)  unf_err <= 1'b1;
    end
  end

  // Push and fill target different slots whenever both are accepted.
  always_ff @(posedge clk) begin
    if (push_acc) ent_q[wr_idx] <= to_push_5a;
    if (fill_acc) ent_q[bp_q - PW'(1)] <= mem_rdata;
  end

endmodule

// File: tb/tb_stack_cache_ctl.sv
// Directed bench for stack_cache_ctl: a per-cycle vector table plus
// hand-written sequences for fill-under-need, async reset and overflow/wrap.
module tb_stack_cache_ctl;

  localparam int unsigned W  = 35;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned MW = 17;
  localparam logic [W-1:0] BIG = 35'h7_FFFF_FFFF;
  localparam logic [W-1:0] AB  = 35'h0AB;

  logic          clk, rst_b;
  logic          pop_2a, push_5a, mem_ack;
  logic [1:0]    need_2a;
  logic [W-1:0]  to_push_5a, mem_rdata;
  logic          stall_2a, mem_req, mem_we, ovf_err, unf_err;
  logic [W-1:0]  top_0_2a, top_n_2a, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] count;
  logic [MW-1:0] mem_count;

  int checks = 0;
  int errors = 0;

  stack_cache_ctl dut (
    .clk(clk), .rst_b(rst_b), .pop_2a(pop_2a), .need_2a(need_2a),
    .push_5a(push_5a), .to_push_5a(to_push_5a), .stall_2a(stall_2a),
    .top_0_2a(top_0_2a), .top_n_2a(top_n_2a), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .count(count),
    .mem_count(mem_count), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          pop;
    logic [1:0]    need;
    logic          push;
    logic [W-1:0]  data;
    logic          ack;
    logic [W-1:0]  rdata;
    logic          e_stall;
    logic [CW-1:0] e_cnt;
    logic [MW-1:0] e_mcnt;
    logic [W-1:0]  e_top0;
    logic [W-1:0]  e_topn;
    logic          e_req;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [W-1:0]  e_wdata;
    logic          e_unf;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(
    input logic p, input logic [1:0] n, input logic pu, input logic [W-1:0] d,
    input logic a, input logic [W-1:0] rd, input logic es, input logic [CW-1:0] ec,
    input logic [MW-1:0] em, input logic [W-1:0] t0, input logic [W-1:0] tn,
    input logic rq, input logic we, input logic [AW-1:0] ad, input logic [W-1:0] wd,
    input logic uf);
    vec_t v;
    v.pop = p; v.need = n; v.push = pu; v.data = d; v.ack = a; v.rdata = rd;
    v.e_stall = es; v.e_cnt = ec; v.e_mcnt = em; v.e_top0 = t0; v.e_topn = tn;
    v.e_req = rq; v.e_we = we; v.e_addr = ad; v.e_wdata = wd; v.e_unf = uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [1:0] n, input logic pu,
                       input logic [W-1:0] d, input logic a, input logic [W-1:0] rd);
    @(negedge clk);
    pop_2a = p; need_2a = n; push_5a = pu; to_push_5a = d; mem_ack = a; mem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic p, input logic [1:0] n, input logic pu,
                      input logic [W-1:0] d, input logic a, input logic [W-1:0] rd);
    drive(p, n, pu, d, a, rd);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    pop_2a = 1'b0; need_2a = 2'd0; push_5a = 1'b0; to_push_5a = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    rst_b = 1'b0;
    pop_2a = 1'b0; need_2a = 2'd0; push_5a = 1'b0; to_push_5a = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    //             pop  need  push  data     ack   rdata   stall cnt   mcnt   top0     topn     req   we    addr   wdata    unf
    vt[0]  = mk(1'b0, 2'd0, 1'b1, 35'h1, 1'b0, 35'h0, 1'b0, 4'd1, 17'd0, 35'h1, 35'h0, 1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[1]  = mk(1'b0, 2'd0, 1'b1, 35'h2, 1'b0, 35'h0, 1'b0, 4'd2, 17'd0, 35'h2, 35'h1, 1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[2]  = mk(1'b0, 2'd0, 1'b1, 35'h3, 1'b0, 35'h0, 1'b0, 4'd3, 17'd0, 35'h3, 35'h2, 1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[3]  = mk(1'b1, 2'd1, 1'b1, BIG,   1'b0, 35'h0, 1'b0, 4'd3, 17'd0, BIG,   35'h2, 1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[4]  = mk(1'b0, 2'd0, 1'b1, 35'h4, 1'b0, 35'h0, 1'b0, 4'd4, 17'd0, 35'h4, BIG,   1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[5]  = mk(1'b0, 2'd0, 1'b1, 35'h5, 1'b0, 35'h0, 1'b0, 4'd5, 17'd0, 35'h5, 35'h4, 1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[6]  = mk(1'b0, 2'd0, 1'b0, 35'h0, 1'b0, 35'h0, 1'b1, 4'd4, 17'd0, 35'h5, 35'h4, 1'b1, 1'b1, 16'd0, 35'h1, 1'b0);
    vt[7]  = mk(1'b0, 2'd0, 1'b0, 35'h0, 1'b0, 35'h0, 1'b0, 4'd4, 17'd0, 35'h5, 35'h4, 1'b1, 1'b1, 16'd0, 35'h1, 1'b0);
    vt[8]  = mk(1'b0, 2'd0, 1'b0, 35'h0, 1'b1, 35'h0, 1'b0, 4'd4, 17'd1, 35'h5, 35'h4, 1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[9]  = mk(1'b1, 2'd0, 1'b0, 35'h0, 1'b0, 35'h0, 1'b0, 4'd3, 17'd1, 35'h4, BIG,   1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[10] = mk(1'b1, 2'd0, 1'b0, 35'h0, 1'b0, 35'h0, 1'b0, 4'd2, 17'd1, BIG,   35'h2, 1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[11] = mk(1'b0, 2'd0, 1'b0, 35'h0, 1'b0, 35'h0, 1'b0, 4'd2, 17'd1, BIG,   35'h2, 1'b1, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[12] = mk(1'b0, 2'd0, 1'b0, 35'h0, 1'b0, 35'h0, 1'b0, 4'd2, 17'd1, BIG,   35'h2, 1'b1, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[13] = mk(1'b0, 2'd0, 1'b0, 35'h0, 1'b1, AB,    1'b0, 4'd3, 17'd0, BIG,   35'h2, 1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[14] = mk(1'b1, 2'd0, 1'b0, 35'h0, 1'b0, 35'h0, 1'b0, 4'd2, 17'd0, 35'h2, AB,    1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[15] = mk(1'b1, 2'd0, 1'b0, 35'h0, 1'b0, 35'h0, 1'b0, 4'd1, 17'd0, AB,    35'h0, 1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[16] = mk(1'b1, 2'd1, 1'b0, 35'h0, 1'b0, 35'h0, 1'b0, 4'd0, 17'd0, 35'h0, 35'h0, 1'b0, 1'b0, 16'd0, 35'h0, 1'b0);
    vt[17] = mk(1'b1, 2'd1, 1'b0, 35'h0, 1'b0, 35'h0, 1'b0, 4'd0, 17'd0, 35'h0, 35'h0, 1'b0, 1'b0, 16'd0, 35'h0, 1'b1);

    // Reset state
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_mem_count", 64'(mem_count), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_stall", 64'(stall_2a), 64'd0);
    chk("rst_errs", 64'({ovf_err, unf_err}), 64'd0);
    chk("rst_top0", 64'(top_0_2a), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Vector table
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].pop, vt[i].need, vt[i].push, vt[i].data, vt[i].ack, vt[i].rdata);
      #1;
      chk($sformatf("v%0d_stall", i), 64'(stall_2a), 64'(vt[i].e_stall));
      tick();
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
      chk($sformatf("v%0d_mem_count", i), 64'(mem_count), 64'(vt[i].e_mcnt));
      chk($sformatf("v%0d_top0", i), 64'(top_0_2a), 64'(vt[i].e_top0));
      chk($sformatf("v%0d_topn", i), 64'(top_n_2a), 64'(vt[i].e_topn));
      chk($sformatf("v%0d_mem_req", i), 64'(mem_req), 64'(vt[i].e_req));
      chk($sformatf("v%0d_unf", i), 64'(unf_err), 64'(vt[i].e_unf));
      chk($sformatf("v%0d_ovf", i), 64'(ovf_err), 64'd0);
      if (vt[i].e_req) begin
        chk($sformatf("v%0d_mem_we", i), 64'(mem_we), 64'(vt[i].e_we));
        chk($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vt[i].e_addr));
        if (vt[i].e_we)
          chk($sformatf("v%0d_mem_wdata", i), 64'(mem_wdata), 64'(vt[i].e_wdata));
      end
    end

    // Fill under need: count=1, mem_count=2, need=2
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b0, 2'd0, 1'b1, W'(i), 1'b0, '0);
    step(1'b0, 2'd0, 1'b0, '0, 1'b1, '0);
    step(1'b0, 2'd0, 1'b0, '0, 1'b0, '0);
    chk("f_spill2_addr", 64'(mem_addr), 64'd1);
    chk("f_spill2_wdata", 64'(mem_wdata), 64'd2);
    step(1'b0, 2'd0, 1'b0, '0, 1'b1, '0);
    chk("f_mem_count2", 64'(mem_count), 64'd2);
    chk("f_count4", 64'(count), 64'd4);
    step(1'b1, 2'd0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 2'd0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 2'd0, 1'b0, '0, 1'b0, '0);
    chk("f_count1", 64'(count), 64'd1);
    chk("f_req", 64'(mem_req), 64'd1);
    chk("f_we", 64'(mem_we), 64'd0);
    chk("f_addr", 64'(mem_addr), 64'd1);
    chk("f_top0", 64'(top_0_2a), 64'd3);
    drive(1'b0, 2'd2, 1'b0, '0, 1'b0, '0);
    #1;
    chk("f_stall_need", 64'(stall_2a), 64'd1);
    tick();
    chk("f_req_held", 64'(mem_req), 64'd1);
    chk("f_addr_held", 64'(mem_addr), 64'd1);
    step(1'b0, 2'd2, 1'b0, '0, 1'b1, AB);
    chk("f_count2", 64'(count), 64'd2);
    chk("f_mem_count1", 64'(mem_count), 64'd1);
    chk("f_topn_ab", 64'(top_n_2a), 64'(AB));
    chk("f_top0_after", 64'(top_0_2a), 64'd3);
    chk("f_stall_clear", 64'(stall_2a), 64'd0);

    // Asynchronous reset in the middle of a spill
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b0, 2'd0, 1'b1, W'(32'h10 + 32'(i)), 1'b0, '0);
    chk("r_spill_req", 64'(mem_req), 64'd1);
    chk("r_spill_we", 64'(mem_we), 64'd1);
    chk("r_spill_wdata", 64'(mem_wdata), 64'h11);
    chk("r_spill_count", 64'(count), 64'd5);
    pop_2a = 1'b0; push_5a = 1'b0;
    #1;
    rst_b = 1'b0;
    #1;
    chk("r_async_req", 64'(mem_req), 64'd0);
    chk("r_async_we", 64'(mem_we), 64'd0);
    chk("r_async_wdata", 64'(mem_wdata), 64'd0);
    chk("r_async_count", 64'(count), 64'd0);
    chk("r_async_stall", 64'(stall_2a), 64'd0);
    chk("r_async_top0", 64'(top_0_2a), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Overflow and pointer wrap with mem_ack held low
    for (int i = 1; i <= 6; i++) step(1'b0, 2'd0, 1'b1, W'(32'h10 + 32'(i)), 1'b0, '0);
    drive(1'b0, 2'd0, 1'b1, 35'h17, 1'b0, '0);
    #1;
    chk("o_stall_guard", 64'(stall_2a), 64'd1);
    tick();
    step(1'b0, 2'd0, 1'b1, 35'h18, 1'b0, '0);
    step(1'b0, 2'd0, 1'b1, 35'h19, 1'b0, '0);
    chk("o_count8", 64'(count), 64'd8);
    chk("o_top0_wrap", 64'(top_0_2a), 64'h19);
    chk("o_topn_wrap", 64'(top_n_2a), 64'h18);
    chk("o_ovf_clear", 64'(ovf_err), 64'd0);
    step(1'b0, 2'd0, 1'b1, 35'h1A, 1'b0, '0);
    chk("o_ovf_set", 64'(ovf_err), 64'd1);
    chk("o_count_hold", 64'(count), 64'd8);
    chk("o_top0_hold", 64'(top_0_2a), 64'h19);
    chk("o_req_held", 64'(mem_req), 64'd1);
    chk("o_stall_full", 64'(stall_2a), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
